// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader
//
// Boot controller for the single-cycle CPU. A host streams (target, address,
// word) records into the loader. Each record becomes a one-cycle write pulse
// on the CPU's instruction or data memory external write port. After the last
// record the loader holds the CPU in reset for RST_HOLD cycles and then
// releases it. It then waits for cpu_done or a timeout, captures the CPU output
// register and reports the session status.
//
// Ports
//   clk_i, rst_n           clock (rising edge), asynchronous active-low reset
//   start                  begin a session; sampled only in IDLE or FINISH
//   s_valid/s_ready        load record handshake
//   s_sel/s_addr/s_data    record: 0 = imem, 1 = dmem, address, word
//   s_last                 marks the final record of the image
//   ex_iwe/ex_iaddr/ex_idata  instruction memory write port
//   ex_dwe/ex_daddr/ex_ddata  data memory write port
//   cpu_rst_n              CPU reset, active low (high only in RUN)
//   cpu_done, cpu_out      CPU flag_done and Out_R
//   result                 Out_R captured when cpu_done was seen
//   cycles_run             RUN cycles of the last session (first cycle = 1)
//   word_cnt               records accepted this session (saturating)
//   busy, done, timeout    session status (done/timeout sticky until start)
//   dbg_state              current FSM state, for checkers
//
// Handshake: a record transfers on a rising edge where s_valid && s_ready.
// s_ready is combinational and is high exactly while the FSM is in LOAD. The
// producer may raise or drop s_valid at any time; the loader never stalls
// inside LOAD, so every valid cycle in LOAD is an accept.

module cpu_boot_loader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 20,
  parameter int TIMEOUT_CYC = 5000,
  parameter int RST_HOLD    = 3
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sel,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              ex_iwe,
  output logic [ADDR_W-1:0] ex_iaddr,
  output logic [DATA_W-1:0] ex_idata,
  output logic              ex_dwe,
  output logic [ADDR_W-1:0] ex_daddr,
  output logic [DATA_W-1:0] ex_ddata,
  output logic              cpu_rst_n,
  input  logic              cpu_done,
  input  logic [DATA_W-1:0] cpu_out,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  cycles_run,
  output logic [15:0]       word_cnt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    HOLD   = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int             HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]    run_next;

  assign s_ready   = (state == LOAD);
  assign dbg_state = state;

  // Cycle count including the current RUN cycle, so the timeout decision and
  // the reported count both treat the first RUN cycle as 1.
  assign run_next = cycles_run + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      ex_iwe     <= 1'b0;
      ex_iaddr   <= '0;
      ex_idata   <= '0;
      ex_dwe     <= 1'b0;
      ex_daddr   <= '0;
      ex_ddata   <= '0;
      cpu_rst_n  <= 1'b0;
      result     <= '0;
      cycles_run <= '0;
      word_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses; addr/data keep their last value.
      ex_iwe <= 1'b0;
      ex_dwe <= 1'b0;

      case (state)
        IDLE, FINISH: begin
          cpu_rst_n <= 1'b0;
          if (start) begin
            state      <= LOAD;
            word_cnt   <= '0;
            cycles_run <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
          end
        end

        LOAD: begin
          if (s_valid) begin
            if (s_sel) begin
              ex_dwe   <= 1'b1;
              ex_daddr <= s_addr;
              ex_ddata <= s_data;
            end else begin
              ex_iwe   <= 1'b1;
              ex_iaddr <= s_addr;
              ex_idata <= s_data;
            end
            if (word_cnt != 16'hFFFF) begin
              word_cnt <= word_cnt + 16'd1;
            end
            if (s_last) begin
              state    <= HOLD;
              hold_cnt <= HOLD_W'(RST_HOLD);
            end
          end
        end

        // The first HOLD cycle carries the last write pulse; the following
        // RST_HOLD cycles are the reset hold proper, then cpu_rst_n rises
        // together with the move to RUN.
        HOLD: begin
          if (hold_cnt == '0) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        RUN: begin
          cycles_run <= run_next;
          if (cpu_done) begin
            // Completion takes priority over a timeout in the same cycle.
            result    <= cpu_out;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b0;
            state     <= FINISH;
          end else if (run_next == TIMEOUT_V) begin
            timeout   <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b0;
            state     <= FINISH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Testbench for cpu_boot_loader: session-level reference model (expected write
// stream, reset-hold length, end-of-run cycle and status computed from the
// record list and the chosen cpu_done cycle) with a write-port scoreboard.

module tb_cpu_boot_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 20;
  localparam int TO     = 16;
  localparam int RH     = 3;
  localparam int REC_W  = 1 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              start, s_valid, s_ready, s_sel, s_last;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              ex_iwe, ex_dwe;
  logic [ADDR_W-1:0] ex_iaddr, ex_daddr;
  logic [DATA_W-1:0] ex_idata, ex_ddata;
  logic              cpu_rst_n, cpu_done;
  logic [DATA_W-1:0] cpu_out, result;
  logic [CNT_W-1:0]  cycles_run;
  logic [15:0]       word_cnt;
  logic              busy, done, timeout;
  logic [2:0]        dbg_state;

  cpu_boot_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .TIMEOUT_CYC(TO), .RST_HOLD(RH)
  ) dut (
    .clk_i(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel),
    .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
    .ex_iwe(ex_iwe), .ex_iaddr(ex_iaddr), .ex_idata(ex_idata),
    .ex_dwe(ex_dwe), .ex_daddr(ex_daddr), .ex_ddata(ex_ddata),
    .cpu_rst_n(cpu_rst_n), .cpu_done(cpu_done), .cpu_out(cpu_out),
    .result(result), .cycles_run(cycles_run), .word_cnt(word_cnt),
    .busy(busy), .done(done), .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [REC_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] exp_result;
  logic [ADDR_W-1:0] last_iaddr, last_daddr;
  logic [DATA_W-1:0] last_idata, last_ddata;
  logic              rec_sel[16];
  logic [ADDR_W-1:0] rec_addr[16];
  logic [DATA_W-1:0] rec_data[16];
  int                rec_n;

  // ---------------- scoreboard: every write pulse must match the queue head ----
  logic [REC_W-1:0] mon_exp;
  always @(negedge clk) begin
    if (ex_iwe || ex_dwe) begin
      check("we_exclusive", 64'(ex_iwe & ex_dwe), '0);
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'({ex_iwe, ex_dwe}), '0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr_rec",
              64'({ex_dwe, (ex_dwe ? ex_daddr : ex_iaddr), (ex_dwe ? ex_ddata : ex_idata)}),
              64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_inputs();
    s_sel  = 1'($urandom_range(0, 1));
    s_addr = 16'($urandom);
    s_data = 16'($urandom);
    s_last = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({s_ready, ex_iwe, ex_dwe, cpu_rst_n, busy, done, timeout}), '0);
    check({tag, "_iport"}, 64'({ex_iaddr, ex_idata}), '0);
    check({tag, "_dport"}, 64'({ex_daddr, ex_ddata}), '0);
    check({tag, "_result"}, 64'(result), '0);
    check({tag, "_cycles"}, 64'(cycles_run), '0);
    check({tag, "_wcnt"}, 64'(word_cnt), '0);
  endtask

  // Asynchronous reset asserted between clock edges, with s_valid held high.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("rst_pending_writes", 64'(exp_q.size()), '0);
    exp_q.delete();
    exp_result = '0;
    last_iaddr = '0; last_idata = '0;
    last_daddr = '0; last_ddata = '0;
    cpu_done   = 1'b0;
    s_valid    = 1'b1;
    repeat (3) begin
      start = 1'($urandom_range(0, 1));
      noise_inputs();
      tick();
      check("in_rst_out", 64'({s_ready, ex_iwe, ex_dwe, cpu_rst_n, busy}), '0);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    start   = 1'b0;
    tick();
    check_all_zero("post_rst");
  endtask

  task automatic load_plan();
    logic [15:0] idat[6];
    idat = '{16'h1166, 16'h1277, 16'h1388, 16'hFB44, 16'hF400, 16'hE040};
    for (int i = 0; i < 6; i++) begin
      rec_sel[i] = 1'b0; rec_addr[i] = 16'(9 + i); rec_data[i] = idat[i];
    end
    rec_sel[6] = 1'b1; rec_addr[6] = 16'h0025; rec_data[6] = 16'h0020;
    rec_sel[7] = 1'b1; rec_addr[7] = 16'h0026; rec_data[7] = 16'h0010;
    rec_n = 8;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) begin
      rec_sel[i]  = 1'($urandom_range(0, 1));
      rec_addr[i] = 16'($urandom);
      rec_data[i] = 16'($urandom);
    end
    rec_n = n;
  endtask

  task automatic check_held_ports();
    check("held_iport", 64'({ex_iaddr, ex_idata}), 64'({last_iaddr, last_idata}));
    check("held_dport", 64'({ex_daddr, ex_ddata}), 64'({last_daddr, last_ddata}));
  endtask

  // One load/run session. done_at: RUN cycle (1-based) on which the CPU model
  // raises cpu_done, 0 = never. dv >= 0 forces Out_R at done. abort_load /
  // abort_run: record index / RUN cycle at which rst_n is pulsed (-1 = none).
  task automatic run_session(input int done_at, input int dv, input int abort_load,
                             input int abort_run);
    int          n_end;
    logic        exp_to;
    logic [15:0] dval;
    dval = '0;

    s_valid = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("start_ready", 64'(s_ready), 64'(1));
    check("start_busy", 64'({busy, done, timeout, cpu_rst_n}), 64'(4'b1000));
    check("start_clear", 64'({word_cnt, cycles_run}), '0);
    check("start_result_kept", 64'(result), 64'(exp_result));

    for (int i = 0; i < rec_n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        noise_inputs();
        start = 1'($urandom_range(0, 1));
        tick();
        check("gap_we", 64'({ex_iwe, ex_dwe}), '0);
        check_held_ports();
      end
      s_valid = 1'b1;
      s_sel   = rec_sel[i];
      s_addr  = rec_addr[i];
      s_data  = rec_data[i];
      s_last  = (i == rec_n - 1);
      start   = 1'($urandom_range(0, 1));
      exp_q.push_back({rec_sel[i], rec_addr[i], rec_data[i]});
      if (rec_sel[i]) begin
        last_daddr = rec_addr[i]; last_ddata = rec_data[i];
      end else begin
        last_iaddr = rec_addr[i]; last_idata = rec_data[i];
      end
      tick();
      check("acc_we", 64'({ex_iwe, ex_dwe}), rec_sel[i] ? 64'(2'b01) : 64'(2'b10));
      check("acc_wcnt", 64'(word_cnt), 64'(i + 1));
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b0;
      if (i == abort_load) begin
        tick();
        do_reset();
        return;
      end
    end

    // Reset hold: exactly RH low cycles after the last write pulse.
    repeat (RH) begin
      s_valid = 1'($urandom_range(0, 1));
      noise_inputs();
      start = 1'($urandom_range(0, 1));
      tick();
      check("hold_low", 64'({cpu_rst_n, s_ready, busy}), 64'(3'b001));
    end
    s_valid = 1'b0;
    start   = 1'b0;
    tick();
    check("run_release", 64'(cpu_rst_n), 64'(1));

    exp_to = !(done_at >= 1 && done_at <= TO);
    n_end  = exp_to ? TO : done_at;
    for (int n = 1; n <= n_end; n++) begin
      check("run_cycles", 64'(cycles_run), 64'(n - 1));
      check("run_flags", 64'({cpu_rst_n, busy, done, timeout, s_ready}), 64'(5'b11000));
      if (n == abort_run) begin
        do_reset();
        return;
      end
      cpu_done = (n == done_at);
      cpu_out  = (cpu_done && dv >= 0) ? 16'(dv) : 16'($urandom);
      if (cpu_done) dval = cpu_out;
      start    = 1'($urandom_range(0, 1));
      s_valid  = 1'($urandom_range(0, 1));
      noise_inputs();
      tick();
    end
    cpu_done = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    if (!exp_to) exp_result = dval;

    check("end_status", 64'({cpu_rst_n, busy, done, timeout}), 64'({3'b001, exp_to}));
    check("end_result", 64'(result), 64'(exp_result));
    check("end_cycles", 64'(cycles_run), 64'(n_end));
    check("end_wcnt", 64'(word_cnt), 64'(rec_n));

    // FINISH holds status and ignores s_valid.
    repeat (2) begin
      s_valid = 1'b1;
      noise_inputs();
      tick();
      check("fin_ready", 64'({s_ready, cpu_rst_n, busy}), '0);
      check("fin_hold", 64'({done, timeout, result, cycles_run}),
            64'({1'b1, exp_to, exp_result, CNT_W'(n_end)}));
    end
    s_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_sel    = 1'b0;
    s_addr   = '0;
    s_data   = '0;
    s_last   = 1'b0;
    cpu_done = 1'b0;
    cpu_out  = '0;
    exp_result = '0;
    last_iaddr = '0; last_idata = '0;
    last_daddr = '0; last_ddata = '0;
    rec_n = 0;

    repeat (2) tick();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // s_valid in IDLE is ignored.
    repeat (3) begin
      s_valid = 1'b1;
      noise_inputs();
      tick();
      check("idle_ready", 64'({s_ready, busy, cpu_rst_n}), '0);
    end
    s_valid = 1'b0;

    load_plan();
    run_session(10, 16'h0077, -1, -1);
    load_random(3);
    run_session(0, -1, -1, -1);           // timeout, result kept
    load_random(4);
    run_session(TO, -1, -1, -1);          // done and timeout in the same cycle
    load_random(5);
    run_session(10, -1, 2, -1);           // reset mid-LOAD
    load_random(3);
    run_session(7, -1, -1, -1);
    load_random(2);
    run_session(12, -1, -1, 5);           // reset mid-RUN
    load_random(4);
    run_session(5, -1, -1, -1);
    repeat (6) begin
      load_random($urandom_range(1, 6));
      run_session($urandom_range(1, 20), -1, -1, -1);
    end

    tick();
    check("final_queue_empty", 64'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
